pc_stack_unit: RTL and testbench

Parametrised program-counter unit with an integrated hardware return-address stack, succeeding the fixed 10-bit increment/load counter. It sits between the control FSM and the instruction memory address mux, supplying the fetch address. It supports:
- increment, absolute jump and PC-relative branch;
- call/return with a bounded LIFO of return addresses;
- sticky stack-error reporting.

---
 rtl/pc_stack_unit.sv | 136 +++++++++++++
 tb/tb_pc_stack_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with increment/jump/relative-branch and a bounded hardware
// return-address stack; error flags are sticky until clr_err.
module pc_stack_unit #(
    parameter int                ADDR_W      = 10,
    parameter int                DISP_W      = 8,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pc_en,
    input  logic [2:0]                         op,
    input  logic [ADDR_W-1:0]                  pc_in,
    input  logic [DISP_W-1:0]                  disp,
    input  logic                               clr_err,
    output logic [ADDR_W-1:0]                  pc_out,
    output logic [ADDR_W-1:0]                  stack_top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               illegal_op
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_INC    = 3'b000;
    localparam logic [2:0] OP_JMP    = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;
    localparam logic [2:0] OP_HOLD   = 3'b101;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [IDX_W-1:0]   top_idx_q, top_idx_d;
    logic [IDX_W-1:0]   wr_idx;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               ill_q, ill_d;
    logic               push;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  pc_branch;
    logic [ADDR_W-1:0]  disp_ext;
    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

    generate
        if (ADDR_W > DISP_W) begin : gen_sext
            assign disp_ext = {{(ADDR_W-DISP_W){disp[DISP_W-1]}}, disp};
        end else begin : gen_trunc
            assign disp_ext = disp[ADDR_W-1:0];
        end
    endgenerate

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign pc_branch = pc_q + disp_ext;

    assign stack_empty = (depth_q == '0);
    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    // top_idx_q tracks the newest entry, so the next free slot is one above it
    assign wr_idx      = stack_empty ? '0 : top_idx_q + IDX_W'(1);
    assign stack_top   = stack_empty ? '0 : stack_mem[top_idx_q];

    always_comb begin
        pc_d      = pc_q;
        depth_d   = depth_q;
        top_idx_d = top_idx_q;
        push      = 1'b0;
        ovf_d     = ovf_q & ~clr_err;
        udf_d     = udf_q & ~clr_err;
        ill_d     = ill_q & ~clr_err;
        if (pc_en) begin
            case (op)
                OP_INC:    pc_d = pc_inc;
                OP_JMP:    pc_d = pc_in;
                OP_BRANCH: pc_d = pc_branch;
                OP_CALL: begin
                    pc_d = pc_in;
                    if (stack_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push      = 1'b1;
                        depth_d   = depth_q + DEPTH_W'(1);
                        top_idx_d = wr_idx;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        pc_d  = pc_inc;
                        udf_d = 1'b1;
                    end else begin
                        pc_d      = stack_mem[top_idx_q];
                        depth_d   = depth_q - DEPTH_W'(1);
                        top_idx_d = top_idx_q - IDX_W'(1);
                    end
                end
                OP_HOLD:   pc_d  = pc_q;
                default:   ill_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_ADDR;
            depth_q   <= '0;
            top_idx_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            depth_q   <= depth_d;
            top_idx_q <= top_idx_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            ill_q     <= ill_d;
        end
    end

    // Return-address storage is not reset; entries are only read once pushed
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

    assign pc_out     = pc_q;
    assign depth      = depth_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed scenarios plus randomized ops checked against a queue-based model.
module tb_pc_stack_unit;

    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int SD   = 8;
    localparam int MASK = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pc_en = 1'b0;
    logic [2:0]    op = 3'b101;
    logic [AW-1:0] pc_in = '0;
    logic [DW-1:0] disp = '0;
    logic          clr_err = 1'b0;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] stack_top;
    logic [3:0]    depth;
    logic          stack_full, stack_empty, overflow, underflow, illegal_op;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int             pc_m;
    logic [AW-1:0]  stk[$];
    logic           ov_m, un_m, il_m;

    pc_stack_unit #(.ADDR_W(AW), .DISP_W(DW), .STACK_DEPTH(SD), .RESET_ADDR('0)) dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .op(op), .pc_in(pc_in),
        .disp(disp), .clr_err(clr_err), .pc_out(pc_out), .stack_top(stack_top),
        .depth(depth), .stack_full(stack_full), .stack_empty(stack_empty),
        .overflow(overflow), .underflow(underflow), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        pc_m = 0;
        stk.delete();
        ov_m = 1'b0; un_m = 1'b0; il_m = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] o, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic en, input logic clr);
        if (clr) begin
            ov_m = 1'b0; un_m = 1'b0; il_m = 1'b0;
        end
        if (en) begin
            case (o)
                3'd0: pc_m = (pc_m + 1) & MASK;
                3'd1: pc_m = int'(a);
                3'd2: pc_m = (pc_m + int'($signed(d))) & MASK;
                3'd3: begin
                    if (stk.size() < SD) stk.push_back(AW'((pc_m + 1) & MASK));
                    else ov_m = 1'b1;
                    pc_m = int'(a);
                end
                3'd4: begin
                    if (stk.size() > 0) pc_m = int'(stk.pop_back());
                    else begin
                        pc_m = (pc_m + 1) & MASK;
                        un_m = 1'b1;
                    end
                end
                3'd5: ;
                default: il_m = 1'b1;
            endcase
        end
    endtask

    // drive one op, clock it, and land 1 time unit after the edge
    task automatic do_op(input logic [2:0] o, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic en, input logic clr);
        op = o; pc_in = a; disp = d; pc_en = en; clr_err = clr;
        @(posedge clk);
        model_step(o, a, d, en, clr);
        #1;
        $display("op=%0d en=%0d clr=%0d pc_in=%03h disp=%02h -> pc=%03h depth=%0d top=%03h ov=%0d un=%0d il=%0d",
                 o, en, clr, a, d, pc_out, depth, stack_top, overflow, underflow, illegal_op);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #7;
        reset = 1'b0;
        vectors++;
        if (pc_out !== 10'h000) begin miscompares++; $display("FAIL reset_pc: got %03h want 000", pc_out); end
        vectors++;
        if ({depth, stack_empty, stack_full, stack_top} !== {4'd0, 1'b1, 1'b0, 10'h000}) begin
            miscompares++; $display("FAIL reset_stack: depth=%0d empty=%0d full=%0d top=%03h", depth, stack_empty, stack_full, stack_top);
        end
        vectors++;
        if ({overflow, underflow, illegal_op} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got %03b want 000", {overflow, underflow, illegal_op});
        end
    endtask

    task automatic test_inc_hold();
        for (int i = 1; i <= 3; i++) begin
            do_op(3'd0, '0, '0, 1'b1, 1'b0);
            vectors++;
            if (pc_out !== AW'(i)) begin miscompares++; $display("FAIL inc: got %03h want %03h", pc_out, AW'(i)); end
        end
        for (int i = 0; i < 2; i++) begin
            do_op(3'd1, 10'h155, '0, 1'b0, 1'b0);
            vectors++;
            if (pc_out !== 10'h003) begin miscompares++; $display("FAIL pc_en_hold: got %03h want 003", pc_out); end
        end
    endtask

    task automatic test_jmp_branch();
        do_op(3'd1, 10'h3FF, '0, 1'b1, 1'b0);
        vectors++;
        if (pc_out !== 10'h3FF) begin miscompares++; $display("FAIL jmp: got %03h want 3ff", pc_out); end
        do_op(3'd0, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (pc_out !== 10'h000) begin miscompares++; $display("FAIL inc_wrap: got %03h want 000", pc_out); end
        do_op(3'd1, 10'h010, '0, 1'b1, 1'b0);
        do_op(3'd2, '0, 8'h80, 1'b1, 1'b0);
        vectors++;
        if (pc_out !== 10'h390) begin miscompares++; $display("FAIL branch_neg: got %03h want 390", pc_out); end
        do_op(3'd2, '0, 8'h05, 1'b1, 1'b0);
        vectors++;
        if (pc_out !== 10'h395) begin miscompares++; $display("FAIL branch_pos: got %03h want 395", pc_out); end
    endtask

    task automatic test_call_ret();
        do_op(3'd1, 10'h020, '0, 1'b1, 1'b0);
        do_op(3'd3, 10'h100, '0, 1'b1, 1'b0);
        vectors++;
        if ({pc_out, stack_top} !== {10'h100, 10'h021}) begin
            miscompares++; $display("FAIL call1: pc=%03h top=%03h want 100/021", pc_out, stack_top);
        end
        do_op(3'd3, 10'h200, '0, 1'b1, 1'b0);
        vectors++;
        if ({depth, stack_top} !== {4'd2, 10'h101}) begin
            miscompares++; $display("FAIL call2: depth=%0d top=%03h want 2/101", depth, stack_top);
        end
        do_op(3'd4, '0, '0, 1'b1, 1'b0);
        vectors++;
        if (pc_out !== 10'h101) begin miscompares++; $display("FAIL ret1: got %03h want 101", pc_out); end
        do_op(3'd4, '0, '0, 1'b1, 1'b0);
        vectors++;
        if ({pc_out, stack_empty} !== {10'h021, 1'b1}) begin
            miscompares++; $display("FAIL ret2: pc=%03h empty=%0d want 021/1", pc_out, stack_empty);
        end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] exp_q[$];
        logic [AW-1:0] cur, tgt;
        do_op(3'd1, 10'h040, '0, 1'b1, 1'b0);
        cur = 10'h040;
        for (int i = 0; i < SD; i++) begin
            tgt = AW'($urandom_range(0, MASK));
            exp_q.push_back(cur + 10'd1);
            do_op(3'd3, tgt, '0, 1'b1, 1'b0);
            cur = tgt;
        end
        vectors++;
        if ({stack_full, depth, overflow} !== {1'b1, 4'd8, 1'b0}) begin
            miscompares++; $display("FAIL fill: full=%0d depth=%0d ov=%0d want 1/8/0", stack_full, depth, overflow);
        end
        do_op(3'd3, 10'h050, '0, 1'b1, 1'b0);
        vectors++;
        if ({pc_out, depth, overflow} !== {10'h050, 4'd8, 1'b1}) begin
            miscompares++; $display("FAIL overflow: pc=%03h depth=%0d ov=%0d want 050/8/1", pc_out, depth, overflow);
        end
        for (int i = 0; i < SD; i++) begin
            tgt = exp_q.pop_back();
            do_op(3'd4, '0, '0, 1'b1, 1'b0);
            vectors++;
            if (pc_out !== tgt) begin miscompares++; $display("FAIL lifo_%0d: got %03h want %03h", i, pc_out, tgt); end
        end
        vectors++;
        if ({stack_empty, overflow} !== 2'b11) begin
            miscompares++; $display("FAIL drained: empty=%0d ov=%0d want 1/1", stack_empty, overflow);
        end
        do_op(3'd5, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_underflow();
        do_op(3'd1, 10'h010, '0, 1'b1, 1'b0);
        do_op(3'd4, '0, '0, 1'b1, 1'b0);
        vectors++;
        if ({pc_out, underflow, overflow} !== {10'h011, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL underflow: pc=%03h un=%0d ov=%0d want 011/1/0", pc_out, underflow, overflow);
        end
        do_op(3'd5, '0, '0, 1'b0, 1'b1);
        vectors++;
        if ({pc_out, underflow} !== {10'h011, 1'b0}) begin
            miscompares++; $display("FAIL clr_err: pc=%03h un=%0d want 011/0", pc_out, underflow);
        end
        do_op(3'd4, '0, '0, 1'b1, 1'b1);
        vectors++;
        if ({pc_out, underflow} !== {10'h012, 1'b1}) begin
            miscompares++; $display("FAIL clr_and_event: pc=%03h un=%0d want 012/1", pc_out, underflow);
        end
        do_op(3'd6, '0, '0, 1'b1, 1'b1);
        vectors++;
        if ({pc_out, underflow, illegal_op} !== {10'h012, 1'b0, 1'b1}) begin
            miscompares++; $display("FAIL clr_other: pc=%03h un=%0d il=%0d want 012/0/1", pc_out, underflow, illegal_op);
        end
    endtask

    task automatic test_async_reset_illegal();
        for (int i = 0; i < 3; i++) do_op(3'd3, AW'(10'h080 + i), '0, 1'b1, 1'b0);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({pc_out, depth, stack_empty, stack_full, stack_top} !== {10'h000, 4'd0, 1'b1, 1'b0, 10'h000}) begin
            miscompares++; $display("FAIL async_reset: pc=%03h depth=%0d empty=%0d full=%0d top=%03h",
                                    pc_out, depth, stack_empty, stack_full, stack_top);
        end
        vectors++;
        if ({overflow, underflow, illegal_op} !== 3'b000) begin
            miscompares++; $display("FAIL async_reset_flags: got %03b want 000", {overflow, underflow, illegal_op});
        end
        #2;
        reset = 1'b0;
        do_op(3'd7, '0, '0, 1'b0, 1'b0);
        vectors++;
        if ({pc_out, illegal_op} !== {10'h000, 1'b0}) begin
            miscompares++; $display("FAIL illegal_gated: pc=%03h il=%0d want 000/0", pc_out, illegal_op);
        end
        do_op(3'd7, '0, '0, 1'b1, 1'b0);
        vectors++;
        if ({pc_out, illegal_op} !== {10'h000, 1'b1}) begin
            miscompares++; $display("FAIL illegal: pc=%03h il=%0d want 000/1", pc_out, illegal_op);
        end
    endtask

    task automatic test_random();
        logic [28:0] got, want;
        logic [2:0]  o;
        for (int i = 0; i < 400; i++) begin
            // bias toward CALL/RET so the stack regularly hits both bounds
            o = ($urandom_range(0, 1) == 1) ? 3'(3 + $urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            do_op(o, AW'($urandom_range(0, MASK)), DW'($urandom_range(0, 255)),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0));
            got  = {pc_out, stack_top, depth, stack_full, stack_empty, overflow, underflow, illegal_op};
            want = {AW'(pc_m), (stk.size() > 0) ? stk[$] : 10'h000, 4'(stk.size()),
                    (stk.size() == SD), (stk.size() == 0), ov_m, un_m, il_m};
            vectors++;
            if (got !== want) begin
                miscompares++; $display("FAIL random_%0d: got %08h want %08h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_hold();
        test_jmp_branch();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_async_reset_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
